// File: rtl/demux8_1_reg.sv
// demux8_1_reg -- 1-to-8 registered demultiplexer with per-lane handshake.
//
// Each input word is steered to one of eight output lanes selected by S.
// Every lane is a single-entry buffer made of a data register and a valid
// flag. A consumer empties a lane by pulsing its Out_Ack bit. A lane that is
// acknowledged in the same cycle it is written keeps its valid flag set,
// so a steady stream can flow through a lane with no bubble.
//
// Ports
//   Clk        in   1     clock, all state changes on the rising edge
//   Reset      in   1     synchronous, active-low
//   S          in   3     destination lane select
//   D_In       in   N     data word for lane S
//   In_Valid   in   1     producer has a word on D_In/S
//   In_Ready   out  1     word on D_In/S is accepted this cycle
//   Q_Out      out  8*N   lane registers, lane i at [i*N +: N]
//   Out_Valid  out  8     lane i holds an unconsumed word
//   Out_Ack    in   8     consumer acknowledge, one bit per lane
//   Xfer_Count out  8     accepted-word counter, wraps at 256
module demux8_1_reg #(
  parameter int N = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [2:0]     S,
  input  logic [N-1:0]   D_In,
  input  logic           In_Valid,
  output logic           In_Ready,
  output logic [8*N-1:0] Q_Out,
  output logic [7:0]     Out_Valid,
  input  logic [7:0]     Out_Ack,
  output logic [7:0]     Xfer_Count
);

  localparam int LANES = 8;

  logic             xfer;
  logic [LANES-1:0] lane_load;
  logic [LANES-1:0] lane_clear;
  logic [LANES-1:0] valid_next;

  // A lane can take a word when it is empty or is being drained this cycle.
  // In_Ready deliberately ignores In_Valid so producer and demux never form
  // a combinational loop; forcing it low under reset keeps the counter still.
  always_comb begin
    In_Ready = Reset & (~Out_Valid[S] | Out_Ack[S]);
  end

  always_comb begin
    xfer = In_Valid & In_Ready;
  end

  // Per-lane load/clear decode. A load wins over a clear on the same lane,
  // which is what gives the bubble-free refill. Acks on empty lanes do
  // nothing because clear is qualified by the current valid flag.
  always_comb begin
    lane_load  = '0;
    lane_clear = '0;
    valid_next = Out_Valid;
    for (int i = 0; i < LANES; i++) begin
      lane_load[i]  = xfer && (S == 3'(i));
      lane_clear[i] = Out_Ack[i] && Out_Valid[i] && !lane_load[i];
      if (lane_load[i]) begin
        valid_next[i] = 1'b1;
      end else if (lane_clear[i]) begin
        valid_next[i] = 1'b0;
      end
    end
  end

  // ---- register stage: lane data, lane valid flags, transfer counter ----
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Q_Out      <= '0;
      Out_Valid  <= '0;
      Xfer_Count <= '0;
    end else begin
      Out_Valid <= valid_next;
      for (int i = 0; i < LANES; i++) begin
        if (lane_load[i]) begin
          Q_Out[i*N +: N] <= D_In;
        end
      end
      if (xfer) begin
        Xfer_Count <= Xfer_Count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_demux8_1_reg.sv
// tb_demux8_1_reg -- directed bench for demux8_1_reg with N=16.
// A behavioural reference model advances with each driven cycle; its
// predicted post-edge state is queued and compared after the edge.
module tb_demux8_1_reg;

  localparam int N = 16;

  logic           Clk;
  logic           Reset;
  logic [2:0]     S;
  logic [N-1:0]   D_In;
  logic           In_Valid;
  logic           In_Ready;
  logic [8*N-1:0] Q_Out;
  logic [7:0]     Out_Valid;
  logic [7:0]     Out_Ack;
  logic [7:0]     Xfer_Count;

  demux8_1_reg #(.N(N)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .S          (S),
    .D_In       (D_In),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Q_Out      (Q_Out),
    .Out_Valid  (Out_Valid),
    .Out_Ack    (Out_Ack),
    .Xfer_Count (Xfer_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]     v;
    logic [8*N-1:0] q;
    logic [7:0]     c;
  } exp_t;

  exp_t exp_fifo[$];

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [7:0]     mv;
  logic [8*N-1:0] mq;
  logic [7:0]     mc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs mid-low-phase, check In_Ready, predict the
  // next state, clock, then compare the DUT state against the prediction.
  task automatic step(input logic [2:0] s, input logic [N-1:0] d, input logic v,
                      input logic [7:0] ack, input logic rst_n);
    logic rdy;
    exp_t e;
    exp_t got;
    @(negedge Clk);
    Reset = rst_n; S = s; D_In = d; In_Valid = v; Out_Ack = ack;
    #1;
    rdy = rst_n & (~mv[s] | ack[s]);
    chk("in_ready", 128'(In_Ready), 128'(rdy));
    if (!rst_n) begin
      mv = '0; mq = '0; mc = '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v && rdy && (s == 3'(i))) begin
          mq[i*N +: N] = d;
          mv[i] = 1'b1;
        end else if (ack[i] && mv[i]) begin
          mv[i] = 1'b0;
        end
      end
      if (v && rdy) mc = mc + 8'd1;
    end
    e.v = mv; e.q = mq; e.c = mc;
    exp_fifo.push_back(e);
    @(posedge Clk);
    #1;
    if (exp_fifo.size() == 0) begin
      checks++; failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      got = exp_fifo.pop_front();
      chk("out_valid",  128'(Out_Valid),  128'(got.v));
      chk("q_out",      128'(Q_Out),      128'(got.q));
      chk("xfer_count", 128'(Xfer_Count), 128'(got.c));
    end
  endtask

  logic [8*N-1:0] fill_img;

  initial begin
    mv = '0; mq = '0; mc = '0;
    Reset = 1'b0; S = '0; D_In = '0; In_Valid = 1'b0; Out_Ack = '0;

    // reset, with a transfer attempt that must not be counted
    step(3'd0, 16'h0000, 1'b0, 8'h00, 1'b0);
    step(3'd2, 16'h5555, 1'b1, 8'h00, 1'b0);
    chk("rst_valid", 128'(Out_Valid), 128'(8'h00));
    chk("rst_q",     128'(Q_Out),     128'd0);
    chk("rst_count", 128'(Xfer_Count), 128'(8'h00));

    // basic transfer
    step(3'd3, 16'hBEEF, 1'b1, 8'h00, 1'b1);
    chk("basic_valid", 128'(Out_Valid), 128'(8'h08));
    chk("basic_lane3", 128'(Q_Out[3*N +: N]), 128'(16'hBEEF));
    chk("basic_count", 128'(Xfer_Count), 128'(8'd1));

    // stall on full lane
    step(3'd3, 16'h1234, 1'b1, 8'h00, 1'b1);
    chk("stall_lane3", 128'(Q_Out[3*N +: N]), 128'(16'hBEEF));
    chk("stall_count", 128'(Xfer_Count), 128'(8'd1));

    // refill with simultaneous ack
    step(3'd3, 16'h1234, 1'b1, 8'h08, 1'b1);
    chk("refill_lane3", 128'(Q_Out[3*N +: N]), 128'(16'h1234));
    chk("refill_valid", 128'(Out_Valid), 128'(8'h08));
    chk("refill_count", 128'(Xfer_Count), 128'(8'd2));

    // drain lane 3
    step(3'd0, 16'h0000, 1'b0, 8'h08, 1'b1);
    chk("drain3_valid", 128'(Out_Valid), 128'(8'h00));

    // fill all lanes, then every select must stall
    fill_img = '0;
    for (int i = 0; i < 8; i++) begin
      step(3'(i), 16'(i), 1'b1, 8'h00, 1'b1);
      fill_img[i*N +: N] = 16'(i);
    end
    chk("fill_valid", 128'(Out_Valid), 128'(8'hFF));
    for (int i = 0; i < 8; i++) step(3'(i), 16'hDEAD, 1'b1, 8'h00, 1'b1);
    chk("full_q", 128'(Q_Out), 128'(fill_img));

    // drain all at once; data stays
    step(3'd0, 16'h0000, 1'b0, 8'hFF, 1'b1);
    chk("drain_valid", 128'(Out_Valid), 128'(8'h00));
    chk("drain_q",     128'(Q_Out),     128'(fill_img));

    // spurious ack on empty lanes
    step(3'd0, 16'h0000, 1'b0, 8'hFF, 1'b1);
    chk("spur_valid", 128'(Out_Valid), 128'(8'h00));
    chk("spur_q",     128'(Q_Out),     128'(fill_img));
    chk("spur_count", 128'(Xfer_Count), 128'(8'd10));

    // mixed traffic with independent multi-lane acks
    for (int k = 0; k < 60; k++) begin
      step(3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)),
           8'($urandom), 1'b1);
    end

    // wrap: 256 transfers from reset
    step(3'd0, 16'h0000, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 256; k++) begin
      step(3'(k % 8), 16'(k), 1'b1, 8'hFF, 1'b1);
    end
    chk("wrap_count", 128'(Xfer_Count), 128'(8'h00));

    // mid-operation reset coincident with a transfer to lane 5
    step(3'd1, 16'h1111, 1'b1, 8'h00, 1'b1);
    step(3'd5, 16'hABCD, 1'b1, 8'h00, 1'b0);
    chk("midrst_valid", 128'(Out_Valid), 128'(8'h00));
    chk("midrst_q",     128'(Q_Out),     128'd0);
    chk("midrst_count", 128'(Xfer_Count), 128'(8'h00));
    chk("midrst_ready", 128'(In_Ready),  128'(1'b0));

    // first edge out of reset accepts
    step(3'd5, 16'hABCD, 1'b1, 8'h00, 1'b1);
    chk("post_valid", 128'(Out_Valid), 128'(8'h20));
    chk("post_lane5", 128'(Q_Out[5*N +: N]), 128'(16'hABCD));
    chk("post_count", 128'(Xfer_Count), 128'(8'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux8_1_reg.md
DEMUX8_1_REG -- requirements
Module: demux8_1_reg

Interface
REQ-001 SHALL have parameter N, default 4, giving the data width of the input and of each output lane.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-low reset sampled on the rising edge of Clk.
REQ-004 SHALL have port S, input, 3, the destination lane select (0..7).
REQ-005 SHALL have port D_In, input, N, the data word to deliver to lane S.
REQ-006 SHALL have port In_Valid, input, 1, high when D_In/S carry a word to transfer.
REQ-007 SHALL have port In_Ready, output, 1, high when the word on D_In/S is accepted this cycle.
REQ-008 SHALL have port Q_Out, output, 8*N, the lane holding registers; lane i occupies bits [i*N +: N].
REQ-009 SHALL have port Out_Valid, output, 8, where bit i is high while lane i holds an unconsumed word.
REQ-010 SHALL have port Out_Ack, input, 8, where bit i is a consumer acknowledge for lane i.
REQ-011 SHALL have port Xfer_Count, output, 8, a running count of accepted input words.

Function
REQ-012 SHALL implement each lane as a 1-entry buffer: register Q_Out lane i plus flag Out_Valid[i].
REQ-013 SHALL drive In_Ready combinationally as Reset & (~Out_Valid[S] | Out_Ack[S]).
REQ-014 SHALL define an input transfer as In_Valid & In_Ready at a rising edge of Clk.
REQ-015 SHALL, on a transfer, load D_In into lane S and set Out_Valid[S] at that edge, giving one-cycle latency from acceptance to Out_Valid.
REQ-016 SHALL, on Out_Ack[i] with Out_Valid[i]=1 and no transfer to lane i, clear Out_Valid[i] at that edge and leave lane i data unchanged.
REQ-017 SHALL, on Out_Ack[i] and a transfer to lane i in the same cycle, load the new word and keep Out_Valid[i]=1 (back-to-back refill, no bubble).
REQ-018 SHALL ignore Out_Ack[i] when Out_Valid[i]=0, with no state change.
REQ-019 SHALL service acknowledges on multiple lanes in the same cycle independently.
REQ-020 SHALL never modify lanes other than S on a transfer.
REQ-021 SHALL hold D_In/S/In_Valid pending with no state change when In_Valid=1 and In_Ready=0, stalling the producer.
REQ-022 SHALL increment Xfer_Count by 1 per transfer, wrapping modulo 256 (255 -> 0).
REQ-023 SHALL NOT permit In_Ready to depend on In_Valid (no combinational loop).

Reset
REQ-024 SHALL, when Reset=0 at a rising edge, clear Q_Out to all zeros, Out_Valid to 8'h00 and Xfer_Count to 8'h00.
REQ-025 SHALL give reset priority over any simultaneous transfer or acknowledge, discarding both.
REQ-026 SHALL hold In_Ready=0 for the whole time Reset=0, so no transfer is counted during reset.
REQ-027 SHALL, after a reset asserted mid-operation, discard all held words and accept a new transfer on the first edge with Reset=1.

Verification
REQ-028 SHALL cover the basic transfer scenario (N=16): after reset, S=3, D_In=16'hBEEF, In_Valid=1 for one cycle -> In_Ready=1; next cycle Out_Valid=8'h08, lane 3=16'hBEEF, Xfer_Count=1.
REQ-029 SHALL cover the stall scenario: lane 3 full, Out_Ack=0, S=3, D_In=16'h1234, In_Valid=1 -> In_Ready=0; lane 3 stays 16'hBEEF; Xfer_Count unchanged.
REQ-030 SHALL cover the refill scenario: lane 3 full, Out_Ack=8'h08, S=3, D_In=16'h1234, In_Valid=1 -> In_Ready=1; next cycle lane 3=16'h1234, Out_Valid[3]=1, Xfer_Count+1.
REQ-031 SHALL cover the fill-all/drain-all scenario: fill lanes 0..7 with 16'h0000..16'h0007 -> Out_Valid=8'hFF, In_Ready=0 for any S; then Out_Ack=8'hFF for one cycle -> Out_Valid=8'h00 and lane data unchanged.
REQ-032 SHALL cover the spurious-ack and wrap scenario: Out_Ack=8'hFF with all lanes empty -> no change; 256 transfers from reset -> Xfer_Count=8'h00.
REQ-033 SHALL cover the mid-operation reset scenario: Reset=0 coincident with a transfer to S=5 -> next cycle Out_Valid=8'h00, Q_Out all zeros, Xfer_Count=0, In_Ready=0 while Reset=0.
